// File: rtl/hash_table_stream_wrapper.sv
// Associative key/value store: searches every entry in one cycle, answers one cycle after the handshake.
// The result register holds its value until ready_i; a new command is taken when it is empty or draining.
module hash_table #(
    parameter int KEY_WIDTH        = 15,
    parameter int DATA_WIDTH       = 15,
    parameter int NUMBER_OF_TABLES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [KEY_WIDTH-1:0]  key_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            delete_write_read_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  key_already_present_o,
    output logic                  no_element_found_o,
    output logic                  no_write_space_o,
    output logic                  no_deletion_target_o,
    output logic                  valid_o,
    input  logic                  ready_i
);
    localparam int IW = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1;

    logic [NUMBER_OF_TABLES-1:0] used_q, used_d;
    logic [KEY_WIDTH-1:0]        key_q [NUMBER_OF_TABLES];
    logic [KEY_WIDTH-1:0]        key_d [NUMBER_OF_TABLES];
    logic [DATA_WIDTH-1:0]       val_q [NUMBER_OF_TABLES];
    logic [DATA_WIDTH-1:0]       val_d [NUMBER_OF_TABLES];
    logic                        res_vld_q, res_vld_d;
    logic [DATA_WIDTH-1:0]       res_dat_q, res_dat_d;
    logic [3:0]                  res_flg_q, res_flg_d;
    logic                        hit, free;
    logic [IW-1:0]               hit_idx, free_idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NUMBER_OF_TABLES; i++) begin
            if (used_q[i] && key_q[i] == key_i && !hit) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!used_q[i] && !free) begin
                free     = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign ready_o = !res_vld_q || ready_i;

    // Flag order: [3] key present, [2] not found, [1] no space, [0] no delete target.
    always_comb begin
        used_d    = used_q;
        key_d     = key_q;
        val_d     = val_q;
        res_vld_d = res_vld_q && !ready_i;
        res_dat_d = res_dat_q;
        res_flg_d = res_flg_q;
        if (valid_i && ready_o) begin
            res_vld_d = 1'b1;
            res_dat_d = '0;
            res_flg_d = '0;
            case (delete_write_read_i)
                2'b00: begin
                    if (hit) res_dat_d = val_q[hit_idx];
                    else     res_flg_d[2] = 1'b1;
                end
                2'b01: begin
                    if (hit) begin
                        res_flg_d[3] = 1'b1;
                    end else if (free) begin
                        used_d[free_idx] = 1'b1;
                        key_d[free_idx]  = key_i;
                        val_d[free_idx]  = data_i;
                    end else begin
                        res_flg_d[1] = 1'b1;
                    end
                end
                2'b10: begin
                    if (hit) used_d[hit_idx] = 1'b0;
                    else     res_flg_d[0] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            used_q    <= '0;
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
            res_flg_q <= '0;
            for (int i = 0; i < NUMBER_OF_TABLES; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            used_q    <= used_d;
            key_q     <= key_d;
            val_q     <= val_d;
            res_vld_q <= res_vld_d;
            res_dat_q <= res_dat_d;
            res_flg_q <= res_flg_d;
        end
    end

    assign valid_o               = res_vld_q;
    assign read_data_o           = res_dat_q;
    assign key_already_present_o = res_flg_q[3];
    assign no_element_found_o    = res_flg_q[2];
    assign no_write_space_o      = res_flg_q[1];
    assign no_deletion_target_o  = res_flg_q[0];
endmodule

// First-word-fall-through FIFO: a push is visible at the head one cycle later.
// Pushes into a full FIFO are ignored; pop_dat_o reads zero while empty.
module stream_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld_i,
    input  logic [W-1:0]             push_dat_i,
    output logic                     full_o,
    output logic                     pop_vld_o,
    input  logic                     pop_rdy_i,
    output logic [W-1:0]             pop_dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o    = cnt_q[AW];
    assign pop_vld_o = |cnt_q;
    assign pop_dat_o = pop_vld_o ? mem_q[rd_q] : '0;
    assign count_o   = cnt_q;
    assign do_push   = push_vld_i && !full_o;
    assign do_pop    = pop_rdy_i && pop_vld_o;

    // Power-of-two depth lets both pointers wrap by plain overflow.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_dat_i;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// Streaming front end for hash_table: skid-registered commands, credit-limited issue, in-order responses.
// Accept-to-valid is 1 + table latency + 1 (STATS: 2); output stalls hold data_o and back up to ready_o.
module hash_table_stream_wrapper #(
    parameter int KEY_WIDTH        = 15,
    parameter int DATA_WIDTH       = 15,
    parameter int NUMBER_OF_TABLES = 10,
    parameter int OUT_WIDTH        = 32,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2+KEY_WIDTH+DATA_WIDTH-1:0] data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic [OUT_WIDTH-1:0]              data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [DATA_WIDTH-1:0]             err_count_o,
    output logic [$clog2(FIFO_DEPTH):0]       in_flight_o
);
    localparam int CW = 2 + KEY_WIDTH + DATA_WIDTH;
    localparam int FW = OUT_WIDTH - 4 - DATA_WIDTH;
    localparam int IW = $clog2(FIFO_DEPTH) + 1;

    logic                  live_q, live_d;
    logic                  cmd_vld_q, cmd_vld_d;
    logic [CW-1:0]         cmd_dat_q, cmd_dat_d;
    logic [IW-1:0]         in_flight_q, in_flight_d;
    logic [DATA_WIDTH-1:0] err_q, err_d;
    logic [1:0]            op;
    logic                  table_op, credit, issue, stats_go, drain, capture, push;
    logic [IW:0]           occupancy;
    logic [OUT_WIDTH-1:0]  push_dat;
    logic                  ht_vld_i, ht_rdy_o, ht_vld_o, ht_rdy_i;
    logic [DATA_WIDTH-1:0] ht_rdata;
    logic [3:0]            ht_flags;
    logic                  fifo_full;
    logic [IW-1:0]         fifo_cnt;

    assign op        = cmd_dat_q[CW-1 -: 2];
    assign table_op  = (op != 2'b11);
    // Every issued command owns a FIFO slot, so results never meet a full FIFO.
    assign occupancy = {1'b0, in_flight_q} + {1'b0, fifo_cnt};
    assign credit    = occupancy < (IW+1)'(FIFO_DEPTH);
    assign ht_vld_i  = cmd_vld_q && table_op && credit;
    assign issue     = ht_vld_i && ht_rdy_o;
    assign stats_go  = cmd_vld_q && !table_op && (in_flight_q == '0) && !fifo_full;
    assign drain     = issue || stats_go;
    assign ready_o   = live_q && (!cmd_vld_q || drain);
    assign ht_rdy_i  = !fifo_full;
    assign capture   = ht_vld_o && ht_rdy_i;
    assign push      = capture || stats_go;
    // An all-zero fill field marks a STATS word.
    assign push_dat  = capture ? {ht_flags, {FW{1'b1}}, ht_rdata}
                               : {4'b0000, {FW{1'b0}}, err_q};

    always_comb begin
        live_d      = 1'b1;
        cmd_vld_d   = cmd_vld_q;
        cmd_dat_d   = cmd_dat_q;
        in_flight_d = in_flight_q;
        err_d       = err_q;
        if (valid_i && ready_o) begin
            cmd_vld_d = 1'b1;
            cmd_dat_d = data_i;
        end else if (drain) begin
            cmd_vld_d = 1'b0;
        end
        case ({issue, capture})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: ;
        endcase
        if (stats_go)
            err_d = '0;
        else if (capture && (|ht_flags) && !(&err_q))
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q      <= 1'b0;
            cmd_vld_q   <= 1'b0;
            cmd_dat_q   <= '0;
            in_flight_q <= '0;
            err_q       <= '0;
        end else begin
            live_q      <= live_d;
            cmd_vld_q   <= cmd_vld_d;
            cmd_dat_q   <= cmd_dat_d;
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
        end
    end

    assign err_count_o = err_q;
    assign in_flight_o = in_flight_q;

    hash_table #(
        .KEY_WIDTH       (KEY_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .NUMBER_OF_TABLES(NUMBER_OF_TABLES)
    ) u_table (
        .clk                  (clk),
        .reset                (reset),
        .key_i                (cmd_dat_q[DATA_WIDTH +: KEY_WIDTH]),
        .data_i               (cmd_dat_q[DATA_WIDTH-1:0]),
        .delete_write_read_i  (op),
        .valid_i              (ht_vld_i),
        .ready_o              (ht_rdy_o),
        .read_data_o          (ht_rdata),
        .key_already_present_o(ht_flags[3]),
        .no_element_found_o   (ht_flags[2]),
        .no_write_space_o     (ht_flags[1]),
        .no_deletion_target_o (ht_flags[0]),
        .valid_o              (ht_vld_o),
        .ready_i              (ht_rdy_i)
    );

    stream_fifo #(
        .W    (OUT_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_vld_i(push),
        .push_dat_i(push_dat),
        .full_o    (fifo_full),
        .pop_vld_o (valid_o),
        .pop_rdy_i (ready_i),
        .pop_dat_o (data_o),
        .count_o   (fifo_cnt)
    );

    a_no_result_drop: assert property (@(posedge clk) disable iff (reset) ht_vld_o |-> ht_rdy_i);
endmodule

// File: tb/tb_hash_table_stream_wrapper.sv
// Directed bench: default wrapper plus a 40-bit/20-bit data variant on one clock and reset.
module tb_hash_table_stream_wrapper;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] data_i1, data_o1;
    logic        valid_i1, ready_o1, valid_o1, ready_i1;
    logic [14:0] err1;
    logic [2:0]  infl1;

    logic [36:0] data_i2;
    logic [39:0] data_o2;
    logic        valid_i2, ready_o2, valid_o2, ready_i2;
    logic [19:0] err2;
    logic [2:0]  infl2;

    int compared   = 0;
    int mismatched = 0;

    hash_table_stream_wrapper dut1 (
        .clk(clk), .reset(reset),
        .data_i(data_i1), .valid_i(valid_i1), .ready_o(ready_o1),
        .data_o(data_o1), .valid_o(valid_o1), .ready_i(ready_i1),
        .err_count_o(err1), .in_flight_o(infl1)
    );

    hash_table_stream_wrapper #(.DATA_WIDTH(20), .OUT_WIDTH(40)) dut2 (
        .clk(clk), .reset(reset),
        .data_i(data_i2), .valid_i(valid_i2), .ready_o(ready_o2),
        .data_o(data_o2), .valid_o(valid_o2), .ready_i(ready_i2),
        .err_count_o(err2), .in_flight_o(infl2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Enter and leave one time unit after a rising edge.
    task automatic send(input int which, input logic [1:0] op, input logic [14:0] key,
                        input logic [19:0] dat);
        logic acc;
        acc = 1'b0;
        if (which == 1) begin
            data_i1  = {op, key, dat[14:0]};
            valid_i1 = 1'b1;
        end else begin
            data_i2  = {op, key, dat};
            valid_i2 = 1'b1;
        end
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = (which == 1) ? ready_o1 : ready_o2;
            @(posedge clk);
            #1;
        end
        if (which == 1) valid_i1 = 1'b0;
        else            valid_i2 = 1'b0;
        check("send_accepted", {63'd0, acc}, 64'd1);
    endtask

    // lat counts falling edges until valid_o is seen (1 = first cycle after the call).
    task automatic recv(input int which, output logic [39:0] d, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        d   = '0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            lat++;
            if ((which == 1) ? valid_o1 : valid_o2) begin
                got = 1'b1;
                d   = (which == 1) ? {8'h00, data_o1} : data_o2;
                if (which == 1) ready_i1 = 1'b1;
                else            ready_i2 = 1'b1;
            end
            @(posedge clk);
            #1;
            if (which == 1) ready_i1 = 1'b0;
            else            ready_i2 = 1'b0;
        end
        check("recv_valid", {63'd0, got}, 64'd1);
    endtask

    initial begin
        logic [39:0] d;
        logic [39:0] resp [8];
        int lat;

        reset    = 1'b1;
        data_i1  = '0; valid_i1 = 1'b0; ready_i1 = 1'b0;
        data_i2  = '0; valid_i2 = 1'b0; ready_i2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_o",   {63'd0, ready_o1}, 64'd0);
        check("rst_valid_o",   {63'd0, valid_o1}, 64'd0);
        check("rst_data_o",    {32'd0, data_o1},  64'd0);
        check("rst_err_count", {49'd0, err1},     64'd0);
        check("rst_in_flight", {61'd0, infl1},    64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_before_first_edge", {63'd0, ready_o1}, 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", {63'd0, ready_o1}, 64'd1);

        // Write then read back, plus a miss.
        send(1, 2'b01, 15'h0005, 20'h01234);
        recv(1, d, lat);
        check("write_resp", {24'd0, d}, 64'h0FFF8000);
        check("write_latency", 64'(lat), 64'd3);
        send(1, 2'b00, 15'h0005, 20'h0);
        recv(1, d, lat);
        check("read_resp", {24'd0, d}, 64'h0FFF9234);
        send(1, 2'b00, 15'h0777, 20'h0);
        recv(1, d, lat);
        check("read_miss_resp", {24'd0, d}, 64'h4FFF8000);
        check("err_after_miss", {49'd0, err1}, 64'd1);

        // Backpressure: four issue, the fifth waits in the register.
        for (int i = 0; i < 4; i++) send(1, 2'b01, 15'(16'h100 + i), 20'(16'h100 + i));
        send(1, 2'b00, 15'h0100, 20'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_ready_o",   {63'd0, ready_o1}, 64'd0);
        check("bp_in_flight", {61'd0, infl1},    64'd0);
        check("bp_valid_o",   {63'd0, valid_o1}, 64'd1);
        check("bp_head_data", {32'd0, data_o1},  64'h0FFF8000);
        repeat (2) @(negedge clk);
        check("bp_head_stable", {32'd0, data_o1}, 64'h0FFF8000);
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 1; i < 4; i++) send(1, 2'b00, 15'(16'h100 + i), 20'h0);
            end
            begin
                logic [39:0] dd;
                int ll;
                for (int i = 0; i < 8; i++) begin
                    recv(1, dd, ll);
                    resp[i] = dd;
                end
            end
        join
        for (int i = 0; i < 8; i++)
            check("bp_order", {24'd0, resp[i]},
                  (i < 4) ? 64'h0FFF8000 : 64'h0FFF8100 + 64'(i - 4));

        // STATS on an idle table returns and clears the error count.
        send(1, 2'b11, 15'h0, 20'h0);
        recv(1, d, lat);
        check("stats1_resp", {24'd0, d}, 64'h00000001);
        check("stats1_latency", 64'(lat), 64'd2);
        check("err_after_stats1", {49'd0, err1}, 64'd0);

        send(1, 2'b00, 15'h0700, 20'h0);
        send(1, 2'b10, 15'h0702, 20'h0);
        send(1, 2'b01, 15'h0005, 20'h02222);
        recv(1, d, lat);
        check("err_read_miss", {24'd0, d}, 64'h4FFF8000);
        recv(1, d, lat);
        check("err_delete_miss", {24'd0, d}, 64'h1FFF8000);
        recv(1, d, lat);
        check("err_key_present", {24'd0, d}, 64'h8FFF8000);
        check("err_count_three", {49'd0, err1}, 64'd3);

        send(1, 2'b00, 15'h0101, 20'h0);
        send(1, 2'b00, 15'h0102, 20'h0);
        send(1, 2'b11, 15'h0, 20'h0);
        recv(1, d, lat);
        check("order_read_a", {24'd0, d}, 64'h0FFF8101);
        recv(1, d, lat);
        check("order_read_b", {24'd0, d}, 64'h0FFF8102);
        recv(1, d, lat);
        check("order_stats", {24'd0, d}, 64'h00000003);
        check("err_after_stats2", {49'd0, err1}, 64'd0);

        // Asynchronous reset with work outstanding.
        send(1, 2'b00, 15'h0101, 20'h0);
        send(1, 2'b00, 15'h0102, 20'h0);
        send(1, 2'b00, 15'h0103, 20'h0);
        check("pre_rst_in_flight", {61'd0, infl1},    64'd1);
        check("pre_rst_valid_o",   {63'd0, valid_o1}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid_o",   {63'd0, valid_o1}, 64'd0);
        check("mid_rst_in_flight", {61'd0, infl1},    64'd0);
        check("mid_rst_ready_o",   {63'd0, ready_o1}, 64'd0);
        check("mid_rst_data_o",    {32'd0, data_o1},  64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(1, 2'b01, 15'h0055, 20'h00ABC);
        recv(1, d, lat);
        check("post_rst_write", {24'd0, d}, 64'h0FFF8000);
        send(1, 2'b00, 15'h0055, 20'h0);
        recv(1, d, lat);
        check("post_rst_read", {24'd0, d}, 64'h0FFF8ABC);

        // Wide variant: flags at 39..36, fill at 35..20.
        send(2, 2'b01, 15'h0005, 20'hABCDE);
        recv(2, d, lat);
        check("wide_write", {24'd0, d}, 64'h0FFFF00000);
        check("wide_write_latency", 64'(lat), 64'd3);
        send(2, 2'b00, 15'h0005, 20'h0);
        recv(2, d, lat);
        check("wide_read", {24'd0, d}, 64'h0FFFFABCDE);
        send(2, 2'b00, 15'h0009, 20'h0);
        recv(2, d, lat);
        check("wide_read_miss", {24'd0, d}, 64'h4FFFF00000);
        check("wide_err_count", {44'd0, err2}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
